// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the multicycle CPU data-memory path.
// Size codes follow the store/load funct3-derived encoding used by the control unit.
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int WAIT_CNT_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/store_align.sv
// Combinational lane alignment for stores: replicates data across byte lanes,
// builds byte enables and flags misaligned or illegal-size accesses.
module store_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    // Each lane picks its source byte; byte enables decide which lanes land.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata[8*gi +: 8] = (size == SZ_WORD) ? data[8*gi +: 8]       :
                                      (size == SZ_HALF) ? data[8*(gi % 2) +: 8] :
                                                          data[7:0];
        end
    endgenerate

    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr;
            SZ_HALF: begin
                be         = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
            end
            SZ_WORD: begin
                be         = BE_WORD;
                misaligned = (addr != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_write_ctrl.sv
// Store-side memory controller: latches one aligned write, holds it until
// mem_ack or a bounded timeout, and pulses done/err back to the control FSM.
module mem_write_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              st_busy,
    output logic              st_done,
    output logic              st_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack
);

    localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(WAIT_MAX - 1);

    wr_state_e             state_reg, state_next;
    logic [WAIT_CNT_W-1:0] cnt_reg, cnt_next;
    logic                  we_reg, we_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;
    logic [ADDR_W-1:0]     addr_reg, addr_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic [3:0]            be_reg, be_next;

    logic [31:0] align_wdata;
    logic [3:0]  align_be;
    logic        align_mis;

    store_align u_align (
        .size       (st_size),
        .addr       (st_addr[1:0]),
        .data       (st_data),
        .wdata      (align_wdata),
        .be         (align_be),
        .misaligned (align_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            be_reg    <= be_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        be_next    = be_reg;
        case (state_reg)
            ST_IDLE: begin
                if (st_req) begin
                    if (align_mis) begin
                        err_next = 1'b1;
                    end else begin
                        addr_next  = {st_addr[ADDR_W-1:2], 2'b00};
                        wdata_next = align_wdata;
                        be_next    = align_be;
                        we_next    = 1'b1;
                        busy_next  = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // Ack is tested first so it beats a coincident timeout.
                if (mem_ack) begin
                    we_next    = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    we_next    = 1'b0;
                    busy_next  = 1'b0;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign st_busy   = busy_reg;
    assign st_done   = done_reg;
    assign st_err    = err_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_be    = be_reg;

endmodule
